// File: rtl/vmem_xbar_pkg.sv
// Shared types and helpers for the channel-to-slice memory crossbar.
// Record fields are sized for the largest supported build (DATA_W<=64, IADDR_W<=32, N_SLICE<=64).
package vmem_xbar_pkg;

  localparam int MAX_ADDR_W = 32;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_BANK_W = 6;

  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic                  we;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
  } req_rec_t;

  typedef struct packed {
    logic                  valid;
    logic [MAX_BANK_W-1:0] bank;
  } trk_t;

endpackage

// File: rtl/vmem_rr_arb.sv
// Per-slice arbiter: one-hot grant among requesting channels.
// RR_ARB_EN selects round-robin with a rotating pointer; otherwise lowest index wins.
module vmem_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

`ifdef RR_ARB_EN
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             found;

  // Two passes: channels at or above the pointer first, then the ones below it.
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        grant[j] = 1'b1;
        found    = 1'b1;
        ptr_nxt  = (j == N - 1) ? '0 : PTR_W'(j + 1);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j < int'(ptr))) begin
        grant[j] = 1'b1;
        found    = 1'b1;
        ptr_nxt  = (j == N - 1) ? '0 : PTR_W'(j + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr <= '0;
    else          ptr <= ptr_nxt;
  end
`else
  logic found;
  logic unused_clk;

  assign unused_clk = clk ^ reset_n;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/vmem_dma_xbar.sv
// Crossbar from N_CH DMA channels onto N_SLICE low-order-interleaved memory slices.
// Build option RR_ARB_EN: round-robin arbitration per slice (default is fixed priority).
module vmem_dma_xbar
  import vmem_xbar_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int N_SLICE = 16,
  parameter  int DATA_W  = 32,
  parameter  int IADDR_W = 16,
  parameter  int RD_LAT  = 1,
  localparam int BANK_W  = log2c(N_SLICE),
  localparam int SADDR_W = IADDR_W - BANK_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_CH-1:0]            req_valid,
  output logic [N_CH-1:0]            req_ready,
  input  logic [N_CH*IADDR_W-1:0]    req_addr,
  input  logic [N_CH*DATA_W-1:0]     req_data,
  input  logic [N_CH-1:0]            req_we,
  output logic [N_CH-1:0]            rsp_valid,
  output logic [N_CH*DATA_W-1:0]     rsp_data,
  output logic [N_SLICE-1:0]         mem_valid,
  output logic [N_SLICE-1:0]         mem_we,
  output logic [N_SLICE*SADDR_W-1:0] mem_addr,
  output logic [N_SLICE*DATA_W-1:0]  mem_wdata,
  input  logic [N_SLICE*DATA_W-1:0]  mem_rdata
);

  req_rec_t          rec      [N_CH];
  logic [BANK_W-1:0] bank     [N_CH];
  trk_t              trk_in   [N_CH];
  trk_t              pipe     [N_CH][RD_LAT+1];
  logic [DATA_W-1:0] rd_sel   [N_CH];
  logic [N_CH-1:0]   slice_req[N_SLICE];
  logic [N_CH-1:0]   slice_gnt[N_SLICE];
  req_rec_t          gnt_rec  [N_SLICE];
  logic              rec_unused;

  always_comb begin
    rec_unused = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      rec[c]                     = '0;
      rec[c].we                  = req_we[c];
      rec[c].addr[IADDR_W-1:0]   = req_addr[c*IADDR_W +: IADDR_W];
      rec[c].data[DATA_W-1:0]    = req_data[c*DATA_W +: DATA_W];
      bank[c]                    = rec[c].addr[BANK_W-1:0];
      rec_unused                 = rec_unused ^ (^rec[c]);
    end
  end

  // Gating with reset_n keeps every grant, and therefore req_ready, low during reset.
  always_comb begin
    for (int s = 0; s < N_SLICE; s++) begin
      slice_req[s] = '0;
      for (int c = 0; c < N_CH; c++) begin
        slice_req[s][c] = reset_n & req_valid[c] & (bank[c] == BANK_W'(s));
      end
    end
  end

  for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
    vmem_rr_arb #(.N(N_CH)) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (slice_req[s]),
      .grant   (slice_gnt[s])
    );
  end

  always_comb begin
    req_ready = '0;
    for (int s = 0; s < N_SLICE; s++) begin
      req_ready = req_ready | slice_gnt[s];
    end
  end

  always_comb begin
    for (int s = 0; s < N_SLICE; s++) begin
      gnt_rec[s] = '0;
      for (int c = 0; c < N_CH; c++) begin
        if (slice_gnt[s][c]) gnt_rec[s] = rec[c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid <= '0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      for (int s = 0; s < N_SLICE; s++) begin
        mem_valid[s] <= |slice_gnt[s];
        mem_we[s]    <= (|slice_gnt[s]) & gnt_rec[s].we;
        if (|slice_gnt[s]) begin
          mem_addr[s*SADDR_W +: SADDR_W] <= gnt_rec[s].addr[IADDR_W-1:BANK_W];
          mem_wdata[s*DATA_W +: DATA_W]  <= gnt_rec[s].data[DATA_W-1:0];
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      trk_in[c]                   = '0;
      trk_in[c].valid             = req_valid[c] & req_ready[c] & ~req_we[c];
      trk_in[c].bank[BANK_W-1:0]  = bank[c];
    end
  end

  // The last stage lines up with the cycle in which the slice presents read data.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      rd_sel[c] = '0;
      for (int s = 0; s < N_SLICE; s++) begin
        if (pipe[c][RD_LAT].bank == MAX_BANK_W'(s)) rd_sel[c] = mem_rdata[s*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k <= RD_LAT; k++) pipe[c][k] <= '0;
      end
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        pipe[c][0] <= trk_in[c];
        for (int k = 1; k <= RD_LAT; k++) pipe[c][k] <= pipe[c][k-1];
        rsp_valid[c] <= pipe[c][RD_LAT].valid;
        if (pipe[c][RD_LAT].valid) rsp_data[c*DATA_W +: DATA_W] <= rd_sel[c];
      end
    end
  end

endmodule

// File: tb/tb_vmem_dma_xbar.sv
// Bench for vmem_dma_xbar: directed scenarios plus random traffic against a
// transaction-level model (per-bank arbitration, address-keyed memory, response schedule).
module tb_vmem_dma_xbar;

  localparam int N_CH    = 4;
  localparam int N_SLICE = 16;
  localparam int DATA_W  = 32;
  localparam int IADDR_W = 16;
  localparam int RD_LAT  = 1;
  localparam int SADDR_W = 12;
  localparam int RSP_DLY = RD_LAT + 2;

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b0;
  logic [N_CH-1:0]            req_valid;
  logic [N_CH-1:0]            req_ready;
  logic [N_CH*IADDR_W-1:0]    req_addr;
  logic [N_CH*DATA_W-1:0]     req_data;
  logic [N_CH-1:0]            req_we;
  logic [N_CH-1:0]            rsp_valid;
  logic [N_CH*DATA_W-1:0]     rsp_data;
  logic [N_SLICE-1:0]         mem_valid;
  logic [N_SLICE-1:0]         mem_we;
  logic [N_SLICE*SADDR_W-1:0] mem_addr;
  logic [N_SLICE*DATA_W-1:0]  mem_wdata;
  logic [N_SLICE*DATA_W-1:0]  mem_rdata;

  always #5 clk = ~clk;

  vmem_dma_xbar #(
    .N_CH(N_CH), .N_SLICE(N_SLICE), .DATA_W(DATA_W), .IADDR_W(IADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_we    (req_we),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Initial content of every location, keyed by full channel address.
  function automatic logic [31:0] pat(input logic [15:0] a);
    return {~a, a} ^ 32'h3C3C_0000;
  endfunction

  // Slice memories: one-cycle registered read.
  logic [31:0] smem [65536];
  bit          swr  [65536];
  logic [31:0] rd_q [N_SLICE];
  logic [15:0] fa;

  always @(posedge clk) begin
    for (int s = 0; s < N_SLICE; s++) begin
      if (mem_valid[s]) begin
        fa = {mem_addr[s*SADDR_W +: SADDR_W], 4'(s)};
        if (mem_we[s]) begin
          smem[fa] <= mem_wdata[s*DATA_W +: DATA_W];
          swr[fa]  <= 1'b1;
        end else begin
          rd_q[s] <= swr[fa] ? smem[fa] : pat(fa);
        end
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    for (int s = 0; s < N_SLICE; s++) mem_rdata[s*DATA_W +: DATA_W] = rd_q[s];
  end

  // Stimulus drive
  logic [N_CH-1:0] drv_valid;
  logic [N_CH-1:0] drv_we;
  logic [15:0]     drv_addr [N_CH];
  logic [31:0]     drv_data [N_CH];

  always_comb begin
    req_valid = drv_valid;
    req_we    = drv_we;
    req_addr  = '0;
    req_data  = '0;
    for (int c = 0; c < N_CH; c++) begin
      req_addr[c*IADDR_W +: IADDR_W] = drv_addr[c];
      req_data[c*DATA_W +: DATA_W]   = drv_data[c];
    end
  end

  // Reference model state
  logic [31:0]        ref_mem [int];
  int                 rr_ptr  [N_SLICE];
  logic [N_SLICE-1:0] exp_mv;
  logic [N_SLICE-1:0] exp_mwe;
  logic [11:0]        exp_maddr [N_SLICE];
  logic [31:0]        exp_mwd   [N_SLICE];
  logic               rs_v [N_CH][8];
  logic [31:0]        rs_d [N_CH][8];

  int              cyc = 0;
  int              n_assert = 0;
  int              n_fail = 0;
  logic [N_CH-1:0] obs_ready;
  logic [N_CH-1:0] t2_exp [4];

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return pat(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive_idle();
    drv_valid = '0;
    drv_we    = '0;
    for (int c = 0; c < N_CH; c++) begin
      drv_addr[c] = '0;
      drv_data[c] = '0;
    end
  endtask

  task automatic set_req(input int c, input logic we, input logic [15:0] a, input logic [31:0] d);
    drv_valid[c] = 1'b1;
    drv_we[c]    = we;
    drv_addr[c]  = a;
    drv_data[c]  = d;
  endtask

  // One clock: check outputs at the falling edge against the model, then advance it.
  task automatic cycle();
    logic [N_CH-1:0] eg;
    logic [N_CH-1:0] erv;
    int slot;
    int s;
    @(negedge clk);
    slot = cyc % 8;
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++)
        for (int k = 0; k < 8; k++) rs_v[c][k] = 1'b0;
      for (int b = 0; b < N_SLICE; b++) rr_ptr[b] = 0;
      exp_mv  = '0;
      exp_mwe = '0;
    end
    eg = '0;
    if (reset_n) begin
      for (int b = 0; b < N_SLICE; b++) begin
        int win;
        win = -1;
`ifdef RR_ARB_EN
        for (int k = 0; k < N_CH; k++) begin
          int c;
          c = (rr_ptr[b] + k) % N_CH;
          if (win < 0 && drv_valid[c] && drv_addr[c][3:0] == 4'(b)) win = c;
        end
        if (win >= 0) rr_ptr[b] = (win + 1) % N_CH;
`else
        for (int c = 0; c < N_CH; c++)
          if (win < 0 && drv_valid[c] && drv_addr[c][3:0] == 4'(b)) win = c;
`endif
        if (win >= 0) eg[win] = 1'b1;
      end
    end
    obs_ready = req_ready;
    chk("req_ready", req_ready, eg);
    chk("mem_valid", mem_valid, exp_mv);
    for (int k = 0; k < N_SLICE; k++) begin
      if (exp_mv[k]) begin
        chk("mem_we", mem_we[k], exp_mwe[k]);
        chk("mem_addr", mem_addr[k*SADDR_W +: SADDR_W], exp_maddr[k]);
        chk("mem_wdata", mem_wdata[k*DATA_W +: DATA_W], exp_mwd[k]);
      end
    end
    for (int c = 0; c < N_CH; c++) erv[c] = rs_v[c][slot];
    chk("rsp_valid", rsp_valid, erv);
    for (int c = 0; c < N_CH; c++) begin
      if (erv[c]) chk("rsp_data", rsp_data[c*DATA_W +: DATA_W], rs_d[c][slot]);
      rs_v[c][slot] = 1'b0;
    end
    if (!reset_n) begin
      chk("rst_mem_addr", |mem_addr, 0);
      chk("rst_mem_wdata", |mem_wdata, 0);
      chk("rst_rsp_data", |rsp_data, 0);
      chk("rst_mem_we", mem_we, 0);
    end
    exp_mv  = '0;
    exp_mwe = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (eg[c]) begin
        s = int'(drv_addr[c][3:0]);
        exp_mv[s]    = 1'b1;
        exp_mwe[s]   = drv_we[c];
        exp_maddr[s] = drv_addr[c][15:4];
        exp_mwd[s]   = drv_data[c];
        if (drv_we[c]) begin
          ref_mem[int'(drv_addr[c])] = drv_data[c];
        end else begin
          rs_v[c][(cyc + RSP_DLY) % 8] = 1'b1;
          rs_d[c][(cyc + RSP_DLY) % 8] = ref_rd(drv_addr[c]);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
`ifdef RR_ARB_EN
    t2_exp[0] = 4'b0001; t2_exp[1] = 4'b0100; t2_exp[2] = 4'b0001; t2_exp[3] = 4'b0100;
`else
    t2_exp[0] = 4'b0001; t2_exp[1] = 4'b0001; t2_exp[2] = 4'b0001; t2_exp[3] = 4'b0001;
`endif
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < 8; k++) rs_v[c][k] = 1'b0;
    exp_mv  = '0;
    exp_mwe = '0;

    // Reset with requests pending: no grants, outputs at reset values.
    drive_idle();
    for (int c = 0; c < N_CH; c++) set_req(c, 1'b0, 16'(c), 32'h0);
    reset_n = 1'b0;
    repeat (2) cycle();
    reset_n = 1'b1;
    drive_idle();
    cycle();

    // Four channels to four different banks in one cycle.
    set_req(0, 1'b0, 16'h0010, 32'h0);
    set_req(1, 1'b0, 16'h0021, 32'h0);
    set_req(2, 1'b0, 16'h0032, 32'h0);
    set_req(3, 1'b0, 16'h0043, 32'h0);
    cycle();
    chk("t1_ready", obs_ready, 4'b1111);
    chk("t1_mem_valid", mem_valid[3:0], 4'hf);
    for (int s = 0; s < 4; s++) chk("t1_mem_addr", mem_addr[s*SADDR_W +: SADDR_W], 12'(s + 1));
    drive_idle();
    cycle();
    cycle();
    chk("t1_rsp_valid", rsp_valid, 4'b1111);
    chk("t1_rsp_data2", rsp_data[2*DATA_W +: DATA_W], pat(16'h0032));
    cycle();

    // ch0 and ch2 collide on bank 5 for four cycles.
    set_req(0, 1'b0, 16'h0005, 32'h0);
    set_req(2, 1'b0, 16'h0015, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t2_grant", obs_ready, t2_exp[k]);
    end
    drive_idle();
    repeat (4) cycle();

    // Write then read back through slice 3.
    set_req(1, 1'b1, 16'h0013, 32'hDEAD_BEEF);
    cycle();
    chk("t3_mem_we", mem_we[3], 1'b1);
    chk("t3_mem_addr", mem_addr[3*SADDR_W +: SADDR_W], 12'h001);
    chk("t3_mem_wdata", mem_wdata[3*DATA_W +: DATA_W], 32'hDEAD_BEEF);
    drive_idle();
    cycle();
    set_req(1, 1'b0, 16'h0013, 32'h0);
    cycle();
    drive_idle();
    cycle();
    chk("t3_no_wr_rsp", rsp_valid, 4'b0000);
    cycle();
    chk("t3_rd_valid", rsp_valid, 4'b0010);
    chk("t3_rd_data", rsp_data[1*DATA_W +: DATA_W], 32'hDEAD_BEEF);
    cycle();

    // ch3 alone on bank 7, then ch0 and ch3 contend: ch0 wins.
    set_req(3, 1'b0, 16'h0007, 32'h0);
    cycle();
    set_req(0, 1'b0, 16'h0017, 32'h0);
    cycle();
    chk("t4_grant", obs_ready, 4'b0001);
    drive_idle();
    repeat (4) cycle();

    // Random traffic over a few banks and addresses to force collisions and RAW hits.
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        drv_valid[c] = ($urandom_range(0, 3) != 0);
        drv_we[c]    = ($urandom_range(0, 3) == 0);
        drv_addr[c]  = {12'($urandom_range(0, 7)), 4'($urandom_range(0, 3))};
        drv_data[c]  = $urandom;
      end
      cycle();
    end
    drive_idle();
    repeat (4) cycle();

    // Reads in flight when reset hits must never respond.
    set_req(0, 1'b0, 16'h0001, 32'h0);
    set_req(1, 1'b0, 16'h0002, 32'h0);
    cycle();
    drive_idle();
    reset_n = 1'b0;
    set_req(2, 1'b0, 16'h0004, 32'h0);
    cycle();
    cycle();
    chk("t6_rst_mem_valid", mem_valid, 0);
    reset_n = 1'b1;
    drive_idle();
    repeat (5) cycle();
    chk("t6_no_rsp", rsp_valid, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vmem_dma_xbar.md
VMEM_DMA_XBAR -- requirements
Module: vmem_dma_xbar

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of DMA channels, 1..16.
REQ-002 SHALL have parameter N_SLICE, default 16: number of memory slices, power of two, 2..64.
REQ-003 SHALL have parameter DATA_W, default 32: word width.
REQ-004 SHALL have parameter IADDR_W, default 16: channel address width; BANK_W = log2(N_SLICE), SADDR_W = IADDR_W-BANK_W.
REQ-005 SHALL have parameter RD_LAT, default 1: slice read latency in cycles, 1..4.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk input 1 system clock; reset_n input 1 async active-low reset.
REQ-007 SHALL provide req_valid, input, N_CH: per-channel request valid.
REQ-008 SHALL provide req_ready, output, N_CH: per-channel grant (combinational).
REQ-009 SHALL provide req_addr, input, N_CH*IADDR_W: bank = addr[BANK_W-1:0], slice address = addr[IADDR_W-1:BANK_W].
REQ-010 SHALL provide req_data, input, N_CH*DATA_W, and req_we, input, N_CH: write data and write enable.
REQ-011 SHALL provide rsp_valid, output, N_CH, and rsp_data, output, N_CH*DATA_W: read response; no backpressure.
REQ-012 SHALL provide mem_valid, output, N_SLICE; mem_we, output, N_SLICE; mem_addr, output, N_SLICE*SADDR_W; mem_wdata, output, N_SLICE*DATA_W: slice port drive, all registered.
REQ-013 SHALL provide mem_rdata, input, N_SLICE*DATA_W: slice read data, valid RD_LAT cycles after the mem_valid cycle.

Function
REQ-014 SHALL arbitrate independently per slice among channels whose req_valid is set and whose bank matches; at most one grant per slice per cycle.
REQ-015 SHALL assert req_ready[c] only when channel c is granted in that cycle; transfer occurs on req_valid&req_ready.
REQ-016 SHALL never assert req_ready for a channel with req_valid low.
REQ-017 SHALL register each accepted request onto its slice port at the next edge; mem_valid SHALL be low on slices with no grant.
REQ-018 SHALL track each accepted read as {valid, bank} in a per-channel shift pipeline of depth RD_LAT+1.
REQ-019 SHALL register rsp_data[c] from mem_rdata of the tracked bank; rsp_valid[c] SHALL rise exactly RD_LAT+2 cycles after acceptance.
REQ-020 SHALL produce no response for writes (req_we=1).
REQ-021 SHALL sustain one request per channel per cycle when banks do not collide; back-to-back reads SHALL return in issue order per channel.
REQ-022 SHALL, when N_CH=1, grant whenever req_valid is high.

Reset
REQ-023 SHALL clear, while reset_n is low, mem_valid, mem_we, rsp_valid, all pipeline valids and arbitration pointers; mem_addr, mem_wdata and rsp_data SHALL be 0.
REQ-024 SHALL discard reads in flight at reset assertion; no response SHALL appear for them after release.
REQ-025 SHALL hold req_ready at 0 while reset_n is low.

Configuration
REQ-026 SHALL, with RR_ARB_EN defined, use per-slice round-robin arbitration: the pointer moves to (granted+1) mod N_CH on every grant and wraps from N_CH-1 to 0.
REQ-027 SHALL, without RR_ARB_EN, use fixed priority, lowest channel index wins, with no pointer state.

Structure
REQ-028 SHALL define in package vmem_xbar_pkg: the log2 helper function, request record typedef {we, addr, data}, and tracking-entry typedef {valid, bank}.
REQ-029 SHALL instantiate sub-module vmem_rr_arb once per slice; it holds the request vector, the grant one-hot and the pointer (pointer only under RR_ARB_EN).

Verification (N_CH=4, N_SLICE=16, RD_LAT=1)
REQ-030 SHALL verify: ch0..3 read addr 0x0010,0x0021,0x0032,0x0043 in one cycle -> all req_ready=1; slices 0..3 mem_addr 1,2,3,4; rsp_valid=4'b1111 3 cycles later with matching data.
REQ-031 SHALL verify: ch0 and ch2 hold reads to bank 5 for 4 cycles -> RR_ARB_EN grants 0,2,0,2; without it, ch0 is granted 4 times and ch2 is never granted.
REQ-032 SHALL verify: ch1 writes addr 0x0013, data 0xDEADBEEF -> slice 3 mem_we=1, mem_addr=1, no rsp_valid; a subsequent read of 0x0013 returns 0xDEADBEEF.
REQ-033 SHALL verify: two reads accepted, then reset_n low 1 cycle after -> rsp_valid stays 0 through and after release; outputs are at reset values.
REQ-034 SHALL verify under RR_ARB_EN: ch3 granted on bank 7, then ch0 and ch3 contend for bank 7 -> ch0 granted (pointer wrapped to 0).
